shift_rs: RTL and testbench

//  Reservation station for the shift functional unit (Execute stage). Holds dispatched SLL/SRL/SRA

---
 rtl/shift_rs_pkg.sv | 31 +++
 rtl/rs_age_matrix.sv | 32 +++
 rtl/shift_rs.sv | 102 ++++++++++
 tb/tb_shift_rs.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_rs_pkg.sv
// shift_rs_pkg: shared CDB packet, ALUop encodings, tag width and station entry layout
package shift_rs_pkg;
    localparam int ROB_W = 4;
    localparam int XLEN  = 32;
    typedef enum logic [3:0] {
        ALU_SLL = 4'h1,
        ALU_SRL = 4'h5,
        ALU_SRA = 4'hD
    } aluop_e;
    typedef struct packed {
        logic [ROB_W-1:0] dest_ROB_entry;
        logic [XLEN-1:0]  result;
        logic             load_step1;
    } CDB_packet_t;
    typedef struct packed {
        logic             valid;
        logic [ROB_W-1:0] rob;
        logic [3:0]       aluop;
        logic [XLEN-1:0]  a_val;
        logic             a_rdy;
        logic [ROB_W-1:0] a_tag;
        logic [XLEN-1:0]  b_val;
        logic             b_rdy;
        logic [ROB_W-1:0] b_tag;
    } rs_entry_t;
    // A waiting operand wakes only on a non-load_step1 broadcast of its producer tag
    function automatic logic tag_hit(input logic cdb_valid, input CDB_packet_t cdb,
                                     input logic rdy, input logic [ROB_W-1:0] tag);
        return cdb_valid && !cdb.load_step1 && !rdy && (tag == cdb.dest_ROB_entry);
    endfunction
endpackage

// File: rtl/rs_age_matrix.sv
// rs_age_matrix: tracks dispatch order of station entries and grants the oldest requester
module rs_age_matrix #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [DEPTH-1:0] alloc_i,
    input  logic [DEPTH-1:0] free_i,
    input  logic [DEPTH-1:0] req_i,
    output logic [DEPTH-1:0] gnt_o
);
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] older_q [DEPTH];
    // older_q[k][i]: entry i was dispatched before entry k; a new entry records every live entry as older
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            vld_q <= '0;
            for (int k = 0; k < DEPTH; k++) older_q[k] <= '0;
        end else begin
            vld_q <= (vld_q & ~free_i) | alloc_i;
            for (int k = 0; k < DEPTH; k++)
                for (int i = 0; i < DEPTH; i++)
                    older_q[k][i] <= alloc_i[k] ? (vld_q[i] && (i != k)) :
                                     alloc_i[i] ? 1'b0 : older_q[k][i];
        end
    end
    // A requester wins when no other requester is older than it
    always_comb begin
        for (int i = 0; i < DEPTH; i++) gnt_o[i] = req_i[i] && !(|(older_q[i] & req_i));
    end
endmodule

// File: rtl/shift_rs.sv
// shift_rs: reservation station for the shift unit with CDB wakeup and oldest-ready issue
module shift_rs
    import shift_rs_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             disp_valid_i,
    output logic             disp_ready_o,
    input  logic [ROB_W-1:0] disp_rob_i,
    input  logic [3:0]       disp_aluop_i,
    input  logic [XLEN-1:0]  disp_a_val_i,
    input  logic             disp_a_rdy_i,
    input  logic [ROB_W-1:0] disp_a_tag_i,
    input  logic [XLEN-1:0]  disp_b_val_i,
    input  logic             disp_b_rdy_i,
    input  logic [ROB_W-1:0] disp_b_tag_i,
    input  logic             cdb_valid_i,
    input  CDB_packet_t      cdb_i,
    input  logic             fu_ready_i,
    output logic             issue_valid_o,
    output logic [XLEN-1:0]  issue_a_o,
    output logic [XLEN-1:0]  issue_b_o,
    output logic [ROB_W-1:0] issue_rob_o,
    output logic [3:0]       issue_aluop_o
);
    rs_entry_t        ent_q [DEPTH];
    rs_entry_t        ent_d [DEPTH];
    rs_entry_t        new_ent;
    logic [DEPTH-1:0] vld, cand, alloc, free, gnt;
    logic             a_hit, b_hit;
    // Occupancy and issue candidates from registered state only
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            vld[i]  = ent_q[i].valid;
            cand[i] = ent_q[i].valid && ent_q[i].a_rdy && ent_q[i].b_rdy;
        end
    end
    assign disp_ready_o  = !(&vld);
    assign alloc         = (disp_valid_i && disp_ready_o && !flush && !reset) ? (~vld & (vld + DEPTH'(1))) : '0;
    assign issue_valid_o = fu_ready_i && (|cand) && !flush && !reset;
    assign free          = issue_valid_o ? gnt : '0;
    rs_age_matrix #(.DEPTH(DEPTH)) u_age (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .alloc_i(alloc),
        .free_i (free),
        .req_i  (cand),
        .gnt_o  (gnt)
    );
    // Incoming entry, capturing a same-cycle CDB result for any operand still waiting
    always_comb begin
        a_hit         = tag_hit(cdb_valid_i, cdb_i, disp_a_rdy_i, disp_a_tag_i);
        b_hit         = tag_hit(cdb_valid_i, cdb_i, disp_b_rdy_i, disp_b_tag_i);
        new_ent.valid = 1'b1;
        new_ent.rob   = disp_rob_i;
        new_ent.aluop = disp_aluop_i;
        new_ent.a_val = a_hit ? cdb_i.result : disp_a_val_i;
        new_ent.a_rdy = disp_a_rdy_i || a_hit;
        new_ent.a_tag = disp_a_tag_i;
        new_ent.b_val = b_hit ? cdb_i.result : disp_b_val_i;
        new_ent.b_rdy = disp_b_rdy_i || b_hit;
        new_ent.b_tag = disp_b_tag_i;
    end
    // Next entry state: wakeup, free on issue, allocate, and flush/reset clearing everything
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].valid && tag_hit(cdb_valid_i, cdb_i, ent_q[i].a_rdy, ent_q[i].a_tag)) begin
                ent_d[i].a_val = cdb_i.result;
                ent_d[i].a_rdy = 1'b1;
            end
            if (ent_q[i].valid && tag_hit(cdb_valid_i, cdb_i, ent_q[i].b_rdy, ent_q[i].b_tag)) begin
                ent_d[i].b_val = cdb_i.result;
                ent_d[i].b_rdy = 1'b1;
            end
            if (free[i]) ent_d[i].valid = 1'b0;
            if (alloc[i]) ent_d[i] = new_ent;
            if (reset || flush) ent_d[i].valid = 1'b0;
        end
    end
    // Entry storage
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
    // Issue payload from the granted entry, zero when nothing is granted
    always_comb begin
        issue_a_o     = '0;
        issue_b_o     = '0;
        issue_rob_o   = '0;
        issue_aluop_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            issue_a_o     = issue_a_o     | ({XLEN{gnt[i]}}  & ent_q[i].a_val);
            issue_b_o     = issue_b_o     | ({XLEN{gnt[i]}}  & ent_q[i].b_val);
            issue_rob_o   = issue_rob_o   | ({ROB_W{gnt[i]}} & ent_q[i].rob);
            issue_aluop_o = issue_aluop_o | ({4{gnt[i]}}     & ent_q[i].aluop);
        end
    end
endmodule

// File: tb/tb_shift_rs.sv
// tb_shift_rs: directed scenarios plus randomized traffic against an in-order queue model
module tb_shift_rs;
    import shift_rs_pkg::*;
    localparam int DEPTH = 4;

    logic        clk, reset, flush, disp_valid_i, disp_ready_o, disp_a_rdy_i, disp_b_rdy_i;
    logic [3:0]  disp_rob_i, disp_aluop_i, disp_a_tag_i, disp_b_tag_i;
    logic [31:0] disp_a_val_i, disp_b_val_i;
    logic        cdb_valid_i, fu_ready_i, issue_valid_o;
    CDB_packet_t cdb_i;
    logic [31:0] issue_a_o, issue_b_o;
    logic [3:0]  issue_rob_o, issue_aluop_o;

    shift_rs #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
        .disp_rob_i(disp_rob_i), .disp_aluop_i(disp_aluop_i),
        .disp_a_val_i(disp_a_val_i), .disp_a_rdy_i(disp_a_rdy_i), .disp_a_tag_i(disp_a_tag_i),
        .disp_b_val_i(disp_b_val_i), .disp_b_rdy_i(disp_b_rdy_i), .disp_b_tag_i(disp_b_tag_i),
        .cdb_valid_i(cdb_valid_i), .cdb_i(cdb_i), .fu_ready_i(fu_ready_i),
        .issue_valid_o(issue_valid_o), .issue_a_o(issue_a_o), .issue_b_o(issue_b_o),
        .issue_rob_o(issue_rob_o), .issue_aluop_o(issue_aluop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  rob, op, at, bt;
        logic [31:0] av, bv;
        logic        ar, br;
    } m_t;
    m_t          mq[$];
    int          m_sel;
    logic        e_ready, e_iv;
    logic [31:0] e_a, e_b;
    logic [3:0]  e_rob, e_op;

    // Expected outputs: entries kept in dispatch order, the first fully-ready one is issued
    task automatic model_eval();
        m_sel = -1;
        for (int i = 0; i < mq.size(); i++) if (m_sel < 0 && mq[i].ar && mq[i].br) m_sel = i;
        e_ready = mq.size() < DEPTH;
        e_iv    = fu_ready_i && m_sel >= 0 && !flush && !reset;
        e_a     = m_sel >= 0 ? mq[m_sel].av  : 32'h0;
        e_b     = m_sel >= 0 ? mq[m_sel].bv  : 32'h0;
        e_rob   = m_sel >= 0 ? mq[m_sel].rob : 4'h0;
        e_op    = m_sel >= 0 ? mq[m_sel].op  : 4'h0;
    endtask

    task automatic model_step();
        m_t  e;
        logic wk;
        wk = cdb_valid_i && !cdb_i.load_step1;
        if (reset || flush) begin
            mq.delete();
        end else begin
            if (e_iv) mq.delete(m_sel);
            for (int i = 0; i < mq.size(); i++) begin
                e = mq[i];
                if (wk && !e.ar && e.at == cdb_i.dest_ROB_entry) begin e.av = cdb_i.result; e.ar = 1'b1; end
                if (wk && !e.br && e.bt == cdb_i.dest_ROB_entry) begin e.bv = cdb_i.result; e.br = 1'b1; end
                mq[i] = e;
            end
            if (disp_valid_i && e_ready) begin
                e.rob = disp_rob_i; e.op = disp_aluop_i;
                e.av = disp_a_val_i; e.ar = disp_a_rdy_i; e.at = disp_a_tag_i;
                e.bv = disp_b_val_i; e.br = disp_b_rdy_i; e.bt = disp_b_tag_i;
                if (wk && !e.ar && e.at == cdb_i.dest_ROB_entry) begin e.av = cdb_i.result; e.ar = 1'b1; end
                if (wk && !e.br && e.bt == cdb_i.dest_ROB_entry) begin e.bv = cdb_i.result; e.br = 1'b1; end
                mq.push_back(e);
            end
        end
    endtask

    task automatic settle();
        model_eval();
        #1;
    endtask

    task automatic tick();
        model_eval();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic v, input logic [3:0] rob, input logic [3:0] op,
                            input logic [31:0] av, input logic ar, input logic [3:0] at,
                            input logic [31:0] bv, input logic br, input logic [3:0] bt);
        disp_valid_i = v; disp_rob_i = rob; disp_aluop_i = op;
        disp_a_val_i = av; disp_a_rdy_i = ar; disp_a_tag_i = at;
        disp_b_val_i = bv; disp_b_rdy_i = br; disp_b_tag_i = bt;
    endtask

    task automatic set_cdb(input logic v, input logic [3:0] dest, input logic [31:0] res, input logic ls);
        cdb_valid_i = v; cdb_i.dest_ROB_entry = dest; cdb_i.result = res; cdb_i.load_step1 = ls;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; fu_ready_i = 1'b1;
        set_disp(1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 0);
        set_cdb(1'b0, 0, 0, 1'b0);
        tick(); tick();
        reset = 1'b0;
        settle();
        checks++;
        if ({disp_ready_o, issue_valid_o, issue_a_o, issue_b_o, issue_rob_o, issue_aluop_o} !== {1'b1, 1'b0, 72'h0}) begin
            errors++;
            $display("FAIL reset: ready=%0b valid=%0b a=%h b=%h rob=%0d op=%0d, want ready=1 valid=0 data 0",
                     disp_ready_o, issue_valid_o, issue_a_o, issue_b_o, issue_rob_o, issue_aluop_o);
        end
    endtask

    task automatic test_basic_issue();
        set_disp(1'b1, 4'd3, ALU_SLL, 32'h1, 1'b1, 0, 32'h4, 1'b1, 0);
        settle();
        checks++;
        if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL basic_empty: valid=%0b want 0", issue_valid_o); end
        tick();
        set_disp(1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 0);
        settle();
        checks++;
        if ({issue_valid_o, issue_a_o, issue_b_o, issue_rob_o, issue_aluop_o} !== {1'b1, 32'h1, 32'h4, 4'd3, ALU_SLL}) begin
            errors++;
            $display("FAIL basic_issue: valid=%0b a=%h b=%h rob=%0d op=%h want 1/1/4/3/%h",
                     issue_valid_o, issue_a_o, issue_b_o, issue_rob_o, issue_aluop_o, ALU_SLL);
        end
        tick();
        settle();
        checks++;
        if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL basic_freed: valid=%0b want 0", issue_valid_o); end
    endtask

    task automatic test_wakeup();
        set_disp(1'b1, 4'd5, ALU_SRA, 32'h80, 1'b1, 0, 32'h0, 1'b0, 4'd7);
        tick();
        set_disp(1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 0);
        set_cdb(1'b1, 4'd7, 32'h99, 1'b1);
        settle();
        checks++;
        if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL wake_waiting: valid=%0b want 0", issue_valid_o); end
        tick();
        set_cdb(1'b1, 4'd7, 32'h2, 1'b0);
        settle();
        checks++;
        if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL wake_load_step1: valid=%0b want 0", issue_valid_o); end
        tick();
        set_cdb(1'b0, 0, 0, 1'b0);
        settle();
        checks++;
        if ({issue_valid_o, issue_a_o, issue_b_o, issue_rob_o} !== {1'b1, 32'h80, 32'h2, 4'd5}) begin
            errors++;
            $display("FAIL wake_issue: valid=%0b a=%h b=%h rob=%0d want 1/80/2/5", issue_valid_o, issue_a_o, issue_b_o, issue_rob_o);
        end
        tick();
    endtask

    task automatic test_bypass();
        set_disp(1'b1, 4'd6, ALU_SRL, 32'h0, 1'b0, 4'd9, 32'h3, 1'b1, 0);
        set_cdb(1'b1, 4'd9, 32'hAB, 1'b0);
        tick();
        set_disp(1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 0);
        set_cdb(1'b0, 0, 0, 1'b0);
        settle();
        checks++;
        if ({issue_valid_o, issue_a_o, issue_b_o, issue_rob_o} !== {1'b1, 32'hAB, 32'h3, 4'd6}) begin
            errors++;
            $display("FAIL bypass: valid=%0b a=%h b=%h rob=%0d want 1/ab/3/6", issue_valid_o, issue_a_o, issue_b_o, issue_rob_o);
        end
        tick();
    endtask

    task automatic test_full();
        fu_ready_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            set_disp(1'b1, 4'(k), ALU_SLL, 32'(k * 16), 1'b1, 0, 32'(k), 1'b1, 0);
            tick();
        end
        set_disp(1'b1, 4'd8, ALU_SRL, 32'h77, 1'b1, 0, 32'h1, 1'b1, 0);
        settle();
        checks++;
        if ({disp_ready_o, issue_valid_o} !== 2'b00) begin
            errors++;
            $display("FAIL full: ready=%0b valid=%0b want 0/0", disp_ready_o, issue_valid_o);
        end
        tick();
        set_disp(1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 0);
        fu_ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            settle();
            checks++;
            if ({issue_valid_o, issue_rob_o, issue_a_o} !== {1'b1, 4'(k), 32'(k * 16)}) begin
                errors++;
                $display("FAIL full_order%0d: valid=%0b rob=%0d a=%h want 1/%0d/%h", k, issue_valid_o, issue_rob_o, issue_a_o, k, k * 16);
            end
            tick();
        end
        settle();
        checks++;
        if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL full_dropped: valid=%0b want 0", issue_valid_o); end
    endtask

    task automatic test_older_blocked();
        fu_ready_i = 1'b0;
        set_disp(1'b1, 4'd10, ALU_SRA, 32'h0, 1'b0, 4'd12, 32'h1, 1'b1, 0);
        tick();
        set_disp(1'b1, 4'd11, ALU_SLL, 32'h5A, 1'b1, 0, 32'h2, 1'b1, 0);
        tick();
        set_disp(1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 0);
        fu_ready_i = 1'b1;
        settle();
        checks++;
        if ({issue_valid_o, issue_rob_o} !== {1'b1, 4'd11}) begin
            errors++;
            $display("FAIL younger_first: valid=%0b rob=%0d want 1/11", issue_valid_o, issue_rob_o);
        end
        tick();
        set_cdb(1'b1, 4'd12, 32'h5, 1'b0);
        settle();
        checks++;
        if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL older_wait: valid=%0b want 0", issue_valid_o); end
        tick();
        set_cdb(1'b0, 0, 0, 1'b0);
        settle();
        checks++;
        if ({issue_valid_o, issue_rob_o, issue_a_o} !== {1'b1, 4'd10, 32'h5}) begin
            errors++;
            $display("FAIL older_after_wake: valid=%0b rob=%0d a=%h want 1/10/5", issue_valid_o, issue_rob_o, issue_a_o);
        end
        tick();
    endtask

    task automatic test_flush();
        fu_ready_i = 1'b0;
        set_disp(1'b1, 4'd1, ALU_SLL, 32'h1, 1'b1, 0, 32'h1, 1'b1, 0);  tick();
        set_disp(1'b1, 4'd2, ALU_SLL, 32'h0, 1'b0, 4'd14, 32'h1, 1'b1, 0); tick();
        set_disp(1'b1, 4'd3, ALU_SLL, 32'h0, 1'b0, 4'd15, 32'h1, 1'b1, 0); tick();
        fu_ready_i = 1'b1; flush = 1'b1;
        set_disp(1'b1, 4'd9, ALU_SRL, 32'h9, 1'b1, 0, 32'h1, 1'b1, 0);
        settle();
        checks++;
        if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL flush_no_issue: valid=%0b want 0", issue_valid_o); end
        tick();
        flush = 1'b0;
        set_disp(1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 0);
        settle();
        checks++;
        if ({disp_ready_o, issue_valid_o, issue_rob_o} !== {1'b1, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL flush_cleared: ready=%0b valid=%0b rob=%0d want 1/0/0", disp_ready_o, issue_valid_o, issue_rob_o);
        end
        tick();
    endtask

    task automatic test_random();
        logic [3:0] ops [3];
        ops[0] = ALU_SLL; ops[1] = ALU_SRL; ops[2] = ALU_SRA;
        for (int n = 0; n < 600; n++) begin
            set_disp(1'($urandom_range(0, 1)), 4'($urandom), ops[$urandom_range(0, 2)],
                     $urandom, 1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 3)),
                     $urandom, 1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 3)));
            set_cdb(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 4) == 0));
            fu_ready_i = 1'($urandom_range(0, 3) != 0);
            flush = 1'($urandom_range(0, 39) == 0);
            settle();
            checks++;
            if ({disp_ready_o, issue_valid_o, issue_a_o, issue_b_o, issue_rob_o, issue_aluop_o} !==
                {e_ready, e_iv, e_a, e_b, e_rob, e_op}) begin
                errors++;
                $display("FAIL random@%0d: ready=%0b valid=%0b a=%h b=%h rob=%0d op=%h want ready=%0b valid=%0b a=%h b=%h rob=%0d op=%h",
                         n, disp_ready_o, issue_valid_o, issue_a_o, issue_b_o, issue_rob_o, issue_aluop_o,
                         e_ready, e_iv, e_a, e_b, e_rob, e_op);
            end
            tick();
        end
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_wakeup();
        test_bypass();
        test_full();
        test_older_blocked();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
